fifo_wr_arbiter: RTL

FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

---
 rtl/fifo_wr_arbiter.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/fifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : fifo_wr_arbiter
// Description : Round-robin arbiter that merges NUM_REQ word streams into one
//               FIFO write port. Optional burst mode: FIFO_ARB_BURST_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_wr_arbiter #(
  parameter int NUM_REQ    = 3,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 4
) (
  input  logic                          w_clk,
  input  logic                          w_rstn,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          full,
  output logic                          w_inc,
  output logic [DATA_WIDTH-1:0]         w_data,
  output logic [1:0]                    grant_id,
  output logic                          busy
);

  if (NUM_REQ < 2 || NUM_REQ > 4) begin : g_chk_num_req
    $error("fifo_wr_arbiter: NUM_REQ must be 2..4");
  end
  if (MAX_BURST < 2 || MAX_BURST > 16) begin : g_chk_max_burst
    $error("fifo_wr_arbiter: MAX_BURST must be 2..16");
  end

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_GRANT = 1'b1
  } state_t;

  state_t    state_q, state_d;
  logic [1:0] grant_id_q, grant_id_d;
  logic [1:0] last_id_q, last_id_d;

`ifdef FIFO_ARB_BURST_EN
  localparam int CNT_W = $clog2(MAX_BURST + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

  logic                  granted;
  logic                  sel_valid;
  logic [DATA_WIDTH-1:0] sel_data;
  logic [2:0]            pick_last;
  logic [2:0]            pick_grant;

  // Returns {found, index} of the first valid requester after base; base
  // itself is considered last.
  function automatic logic [2:0] rr_pick(input logic [1:0] base,
                                         input logic [NUM_REQ-1:0] vld);
    logic [2:0] res;
    int         best;
    int         d;
    res  = '0;
    best = NUM_REQ + 1;
    for (int j = 0; j < NUM_REQ; j++) begin
      d = j - int'(base);
      if (d <= 0) d = d + NUM_REQ;
      if (vld[j] && d < best) begin
        best = d;
        res  = {1'b1, 2'(j)};
      end
    end
    return res;
  endfunction

  assign granted    = (state_q == S_GRANT) && w_rstn;
  assign pick_last  = rr_pick(last_id_q, req_valid);
  assign pick_grant = rr_pick(grant_id_q, req_valid);

  always_comb begin
    sel_valid = 1'b0;
    sel_data  = '0;
    req_ready = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_id_q == 2'(i)) begin
        sel_valid    = req_valid[i];
        sel_data     = req_data[i*DATA_WIDTH +: DATA_WIDTH];
        req_ready[i] = granted && !full;
      end
    end
  end

  assign w_inc    = granted && sel_valid && !full;
  assign w_data   = granted ? sel_data : '0;
  assign busy     = granted;
  assign grant_id = grant_id_q;

  always_comb begin
    state_d    = state_q;
    grant_id_d = grant_id_q;
    last_id_d  = last_id_q;
`ifdef FIFO_ARB_BURST_EN
    cnt_d      = cnt_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (pick_last[2]) begin
          state_d    = S_GRANT;
          grant_id_d = pick_last[1:0];
        end
      end
      default: begin
        if (full) begin
          state_d = S_GRANT;
        end else if (!sel_valid) begin
          state_d = S_IDLE;
`ifdef FIFO_ARB_BURST_EN
          cnt_d   = '0;
`endif
        end else begin
          last_id_d = grant_id_q;
`ifdef FIFO_ARB_BURST_EN
          if ((cnt_q + 1'b1) < CNT_W'(MAX_BURST)) begin
            cnt_d = cnt_q + 1'b1;
          end else begin
            cnt_d = '0;
            if (pick_grant[2]) grant_id_d = pick_grant[1:0];
            else               state_d    = S_IDLE;
          end
`else
          if (pick_grant[2]) grant_id_d = pick_grant[1:0];
          else               state_d    = S_IDLE;
`endif
        end
      end
    endcase
  end

  always_ff @(posedge w_clk) begin
    if (!w_rstn) begin
      state_q    <= S_IDLE;
      grant_id_q <= 2'd0;
      last_id_q  <= 2'(NUM_REQ - 1);
`ifdef FIFO_ARB_BURST_EN
      cnt_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      grant_id_q <= grant_id_d;
      last_id_q  <= last_id_d;
`ifdef FIFO_ARB_BURST_EN
      cnt_q      <= cnt_d;
`endif
    end
  end

endmodule
`default_nettype wire
